tlul_mem_tester: RTL and testbench
==================================

TLUL_MEM_TESTER -- requirements
Module: tlul_mem_tester

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_ni  input  1  asynchronous reset, active-low.
REQ-004 start_i  input  1  begin a test run; sampled only in IDLE.
REQ-005 base_addr_i  input  32  first byte address; bits [1:0] ignored and treated as 0.
REQ-006 num_words_i  input  16  number of 32-bit words to write, then read back.
REQ-007 seed_i  input  32  pattern seed.
REQ-008 tl_o  output  tlul_pkg::tl_h2d_t  TL-UL host request channel A and d_ready.
REQ-009 tl_i  input  tlul_pkg::tl_d2h_t  TL-UL device response channel D and a_ready.
REQ-010 busy_o  output  1  run in progress.
REQ-011 done_o  output  1  last run complete; sticky until the next accepted start.
REQ-012 pass_o  output  1  last run had zero errors; valid while done_o=1.
REQ-013 err_count_o  output  16  number of mismatching or erroring responses; saturates at 16'hFFFF.
REQ-014 first_err_addr_o  output  32  address of the first error in the current run; 0 if there is none.

Function
REQ-015 FSM states SHALL be IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, with at most one outstanding TL-UL transaction at any time.
REQ-016 Word address SHALL be addr(i) = {base_addr_i[31:2],2'b0} + 4*i, computed modulo 2^32 so that it wraps past 32'hFFFFFFFC.
REQ-017 Pattern SHALL be pat(i) = addr(i) XOR seed_i XOR {16'h0, i}.
REQ-018 IDLE with start_i=1 and num_words_i!=0: latch the inputs, clear err_count_o, first_err_addr_o and done_o, set busy_o, set i=0, go to WR_REQ; a_valid SHALL be 1 in the following cycle.
REQ-019 IDLE with start_i=1 and num_words_i=0: done_o=1 and pass_o=1 in the following cycle, with no TL-UL traffic.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 WR_REQ SHALL drive a_valid=1, a_opcode=PutFullData, a_size=2, a_mask=4'hF, a_address=addr(i), a_data=pat(i), a_source=0, a_param=0, and a_user=TL_A_USER_DEFAULT.
REQ-022 On a_valid&&a_ready, WR_REQ SHALL go to WR_RSP.
REQ-023 RD_REQ SHALL be identical to WR_REQ except that a_opcode=Get, and on a_valid&&a_ready it SHALL go to RD_RSP.
REQ-024 All A-channel fields SHALL be held stable while a_valid=1 and a_ready=0, and a_valid SHALL NOT drop before the handshake completes.
REQ-025 d_ready SHALL be 1 only in WR_RSP and RD_RSP; d_valid in any other state SHALL be ignored.
REQ-026 WR_RSP on d_valid: count an error if d_error=1 or d_opcode!=AccessAck.
REQ-027 WR_RSP then SHALL go to WR_REQ with i+1, or to RD_REQ with i=0 after the last word.
REQ-028 RD_RSP on d_valid: count an error if d_error=1, d_opcode!=AccessAckData, or d_data!=pat(i).
REQ-029 RD_RSP then SHALL go to RD_REQ with i+1, or after the last word to IDLE with busy_o=0, done_o=1, and pass_o=(err_count==0).
REQ-030 On the first error of a run, first_err_addr_o SHALL capture addr(i) and is not updated again within that run.
REQ-031 err_count_o SHALL increment by 1 per erroring response and SHALL NOT wrap past 16'hFFFF.
REQ-032 d_valid arriving in the same cycle as the a_ready handshake SHALL NOT be accepted; it SHALL be accepted in the next cycle, in the RSP state.

Reset
REQ-033 On rst_ni=0 the FSM SHALL go to IDLE immediately, with a_valid=0, d_ready=0, busy_o=0, done_o=0, pass_o=0, err_count_o=0, first_err_addr_o=0, and all A-channel fields at 0 except a_user, which is TL_A_USER_DEFAULT.
REQ-034 Reset asserted mid-run SHALL abort the run with no completion indication, and no stale response SHALL be counted after reset release.

Structure
REQ-035 State enum and the pattern function SHALL live in tlul_mem_tester_pkg.
REQ-036 TL-UL types and opcode constants SHALL come from tlul_pkg.
REQ-037 No sub-module is required, and the block SHALL be instantiable in place of the DMA host on the ddr4_tlul_xilinx main-memory port.

Verification
REQ-038 Bench: base=32'h1000, n=4, seed=32'hA5A5A5A5, ideal memory with 0-cycle a_ready -> 4 PutFullData then 4 Get at 0x1000..0x100C; done_o=1, pass_o=1, err_count_o=0.
REQ-039 Bench: same as REQ-038, but memory corrupts bit 0 of the word at 0x1008 -> err_count_o=1, first_err_addr_o=32'h1008, pass_o=0.
REQ-040 Bench: a_ready held low for 5 cycles per request, random 0..7-cycle D latency -> A fields stable throughout, one transaction outstanding at a time, pass_o=1.
REQ-041 Bench: n=0 -> done_o=1, pass_o=1 one cycle after start_i, with no a_valid.
REQ-042 Bench: base=32'hFFFFFFF8, n=4 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004; pass_o=1.
REQ-043 Bench: rst_ni pulsed low in RD_RSP with d_error=1 on every response and start_i held high -> outputs at reset values; after release, a fresh run starts and start_i is ignored while busy_o=1.

Source files
------------

// File: rtl/tlul_mem_tester_pkg.sv
// Memory tester state encoding plus the address and pattern helpers.
package tlul_mem_tester_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrReq = 3'd1,
    StWrRsp = 3'd2,
    StRdReq = 3'd3,
    StRdRsp = 3'd4
  } state_e;

  // Word address of index idx; the 32-bit add wraps naturally past 32'hFFFFFFFC.
  function automatic logic [31:0] word_addr(logic [31:0] base, logic [15:0] idx);
    return {base[31:2], 2'b00} + {14'h0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] pattern(logic [31:0] addr, logic [31:0] seed,
                                          logic [15:0] idx);
    return addr ^ seed ^ {16'h0, idx};
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type slice: host/device channel structs and opcode constants.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  // Data access (instr_type = MuBi4False), integrity fields left to downstream gen.
  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    instr_type: 4'h9,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_mem_tester.sv
// TL-UL memory tester: writes a seeded pattern to N words, reads them back and
// counts mismatching or erroring responses. One transaction outstanding at a time.
module tlul_mem_tester
  import tlul_mem_tester_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [31:0]       base_addr_i,
  input  logic [15:0]       num_words_i,
  input  logic [31:0]       seed_i,
  output tlul_pkg::tl_h2d_t tl_o,
  input  tlul_pkg::tl_d2h_t tl_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_count_o,
  output logic [31:0]       first_err_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] num_q, num_d;
  logic [15:0] idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] first_err_q, first_err_d;

  logic [31:0] cur_addr;
  logic [31:0] cur_pat;
  logic        last_word;
  logic        a_fire;
  logic        d_fire;
  logic        rsp_err;
  logic [15:0] err_cnt_sat;
  logic        unused_tl_d;

  assign cur_addr    = word_addr(base_q, idx_q);
  assign cur_pat     = pattern(cur_addr, seed_q, idx_q);
  assign last_word   = (idx_q == num_q - 16'd1);
  assign a_fire      = tl_o.a_valid & tl_i.a_ready;
  assign d_fire      = tl_o.d_ready & tl_i.d_valid;
  assign err_cnt_sat = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
  assign unused_tl_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink, tl_i.d_user};

  // A-channel request and d_ready decoded purely from registered state, so fields
  // stay stable for the whole time a request waits on a_ready.
  always_comb begin
    tl_o        = '0;
    tl_o.a_user = tlul_pkg::TL_A_USER_DEFAULT;
    unique case (state_q)
      StWrReq, StRdReq: begin
        tl_o.a_valid   = 1'b1;
        tl_o.a_opcode  = (state_q == StRdReq) ? tlul_pkg::Get : tlul_pkg::PutFullData;
        tl_o.a_size    = 2'd2;
        tl_o.a_mask    = 4'hF;
        tl_o.a_address = cur_addr;
        tl_o.a_data    = cur_pat;
      end
      StWrRsp, StRdRsp: tl_o.d_ready = 1'b1;
      default: ;
    endcase
  end

  // Response check: writes expect a plain ack, reads expect data equal to the pattern.
  always_comb begin
    rsp_err = tl_i.d_error;
    if (state_q == StRdRsp) begin
      if ((tl_i.d_opcode != tlul_pkg::AccessAckData) || (tl_i.d_data != cur_pat)) begin
        rsp_err = 1'b1;
      end
    end else if (tl_i.d_opcode != tlul_pkg::AccessAck) begin
      rsp_err = 1'b1;
    end
  end

  // Next-state, index and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    seed_d      = seed_q;
    num_d       = num_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    // d_fire only occurs in the RSP states, so this never collides with the IDLE clear.
    if (d_fire && rsp_err) begin
      err_cnt_d = err_cnt_sat;
      if (err_cnt_q == 16'd0) first_err_d = cur_addr;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          err_cnt_d   = 16'd0;
          first_err_d = 32'd0;
          if (num_words_i == 16'd0) begin
            done_d = 1'b1;
            pass_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
            base_d  = base_addr_i;
            seed_d  = seed_i;
            num_d   = num_words_i;
            idx_d   = 16'd0;
            state_d = StWrReq;
          end
        end
      end
      StWrReq: if (a_fire) state_d = StWrRsp;
      StWrRsp: begin
        if (d_fire) begin
          if (last_word) begin
            idx_d   = 16'd0;
            state_d = StRdReq;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = StWrReq;
          end
        end
      end
      StRdReq: if (a_fire) state_d = StRdRsp;
      StRdRsp: begin
        if (d_fire) begin
          if (last_word) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == 16'd0);
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any run with no completion indication.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_q      <= 32'd0;
      seed_q      <= 32'd0;
      num_q       <= 16'd0;
      idx_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 16'd0;
      first_err_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_tlul_mem_tester.sv
// Bench for tlul_mem_tester: randomized memory responder, expected-transaction
// scoreboard filled at run start, and an independent A/D channel monitor.
module tb_tlul_mem_tester;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              start;
  logic [31:0]       base;
  logic [15:0]       num;
  logic [31:0]       seed;
  tlul_pkg::tl_h2d_t tl_h2d;
  tlul_pkg::tl_d2h_t tl_d2h;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [31:0]       first_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder knobs and reference-model results.
  int          a_delay     = 0;
  int          d_lat_max   = 0;
  bit          derr        = 1'b0;
  bit          corrupt_en  = 1'b0;
  logic [31:0] corrupt_adr = 32'h0;
  bit          spurious    = 1'b0;
  int          exp_err     = 0;
  logic [31:0] exp_first   = 32'h0;
  txn_t        exp_q[$];
  logic [31:0] mem[logic [31:0]];

  always #5 clk = ~clk;

  tlul_mem_tester dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .start_i          (start),
    .base_addr_i      (base),
    .num_words_i      (num),
    .seed_i           (seed),
    .tl_o             (tl_h2d),
    .tl_i             (tl_d2h),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: queue every expected request and predict the error tally.
  task automatic arm(input logic [31:0] b, input int n, input logic [31:0] s);
    txn_t        t;
    logic [31:0] a;
    exp_err   = 0;
    exp_first = 32'h0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < n; i++) begin
        a      = (b & 32'hFFFF_FFFC) + 32'(4 * i);
        t.rd   = (ph == 1);
        t.addr = a;
        t.data = a ^ s ^ 32'(i);
        exp_q.push_back(t);
        if (derr || (ph == 1 && corrupt_en && a == corrupt_adr)) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end
    end
    base = b;
    num  = 16'(n);
    seed = s;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_a_valid", {31'h0, tl_h2d.a_valid}, 32'h1);
    check("start_busy", {31'h0, busy}, 32'h1);
    // Scramble the inputs: the run must use the values latched at start.
    base = $urandom;
    num  = 16'($urandom);
    seed = $urandom;
  endtask

  task automatic finish_run(input string name);
    int cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({name, "_done"}, {31'h0, done}, 32'h1);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_pass"}, {31'h0, pass}, {31'h0, exp_err == 0});
    check({name, "_errs"}, {16'h0, err_count}, 32'(exp_err));
    check({name, "_first"}, first_err, exp_first);
    check({name, "_left"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic zero_run(input string name);
    arm(32'h4000, 0, 32'h1234_5678);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_done"}, {31'h0, done}, 32'h1);
    check({name, "_pass"}, {31'h0, pass}, 32'h1);
    check({name, "_errs"}, {16'h0, err_count}, 32'h0);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_a_valid"}, {31'h0, tl_h2d.a_valid}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_a_valid"}, {31'h0, tl_h2d.a_valid}, 32'h0);
    check({name, "_d_ready"}, {31'h0, tl_h2d.d_ready}, 32'h0);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_done"}, {31'h0, done}, 32'h0);
    check({name, "_pass"}, {31'h0, pass}, 32'h0);
    check({name, "_errs"}, {16'h0, err_count}, 32'h0);
    check({name, "_first"}, first_err, 32'h0);
    check({name, "_a_addr"}, tl_h2d.a_address, 32'h0);
    check({name, "_a_data"}, tl_h2d.a_data, 32'h0);
    check({name, "_a_op"}, {29'h0, tl_h2d.a_opcode}, 32'h0);
    check({name, "_a_mask"}, {28'h0, tl_h2d.a_mask}, 32'h0);
    check({name, "_a_user"}, {14'h0, tl_h2d.a_user}, 32'h0002_4000);
  endtask

  // Memory responder: inputs change at negedge, so each handshake decision is fixed
  // for the following rising edge.
  initial begin
    bit                   outstanding = 1'b0;
    bit                   d_will_fire = 1'b0;
    bit                   a_fire_now;
    int                   a_wait = 0;
    int                   d_cnt = 0;
    int                   d_lat = 0;
    tlul_pkg::tl_d_op_e   rsp_op = tlul_pkg::AccessAck;
    logic [31:0]          rsp_data = 32'h0;
    tl_d2h = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        tl_d2h      = '0;
        outstanding = 1'b0;
        d_will_fire = 1'b0;
        a_wait      = 0;
        continue;
      end
      a_fire_now = 1'b0;
      if (d_will_fire) begin
        outstanding = 1'b0;
        d_will_fire = 1'b0;
      end
      tl_d2h.a_ready = 1'b0;
      if (tl_h2d.a_valid && !outstanding) begin
        if (a_wait >= a_delay) begin
          tl_d2h.a_ready = 1'b1;
          a_fire_now     = 1'b1;
          a_wait         = 0;
          if (tl_h2d.a_opcode == tlul_pkg::PutFullData) begin
            mem[tl_h2d.a_address] = tl_h2d.a_data ^
                {31'h0, corrupt_en && tl_h2d.a_address == corrupt_adr};
            rsp_op   = tlul_pkg::AccessAck;
            rsp_data = 32'h0;
          end else begin
            rsp_op   = tlul_pkg::AccessAckData;
            rsp_data = mem.exists(tl_h2d.a_address) ? mem[tl_h2d.a_address] : 32'hDEAD_BEEF;
          end
          d_lat = int'($urandom_range(d_lat_max, 0));
          d_cnt = 0;
        end else begin
          a_wait++;
        end
      end
      if (outstanding) begin
        if (d_cnt >= d_lat) begin
          tl_d2h.d_valid  = 1'b1;
          tl_d2h.d_opcode = rsp_op;
          tl_d2h.d_data   = rsp_data;
          tl_d2h.d_error  = derr;
          if (tl_h2d.d_ready) d_will_fire = 1'b1;
        end else begin
          tl_d2h.d_valid = 1'b0;
          d_cnt++;
        end
      end else begin
        // Stray erroring responses that the tester must never accept.
        tl_d2h.d_valid  = spurious;
        tl_d2h.d_opcode = tlul_pkg::AccessAckData;
        tl_d2h.d_data   = $urandom;
        tl_d2h.d_error  = 1'b1;
      end
      if (a_fire_now) outstanding = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each A handshake and polices channel rules.
  initial begin
    tlul_pkg::tl_h2d_t prev;
    bit                prev_pend = 1'b0;
    int                outst = 0;
    txn_t              t;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_ni) begin
        prev_pend = 1'b0;
        outst     = 0;
        continue;
      end
      if (prev_pend) begin
        check("a_valid_held", {31'h0, tl_h2d.a_valid}, 32'h1);
        check("a_addr_stable", tl_h2d.a_address, prev.a_address);
        check("a_all_stable", {31'h0, tl_h2d != prev}, 32'h0);
      end
      if (tl_h2d.a_valid) check("a_while_outstanding", 32'(outst), 32'h0);
      if (tl_h2d.d_ready) check("d_ready_without_req", 32'(outst), 32'h1);
      if (tl_h2d.a_valid && tl_d2h.a_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_a: got request at %h, required none", tl_h2d.a_address);
        end else begin
          t = exp_q.pop_front();
          check("a_opcode", {29'h0, tl_h2d.a_opcode}, t.rd ? 32'h4 : 32'h0);
          check("a_address", tl_h2d.a_address, t.addr);
          check("a_data", tl_h2d.a_data, t.data);
          check("a_mask", {28'h0, tl_h2d.a_mask}, 32'hF);
          check("a_size", {30'h0, tl_h2d.a_size}, 32'h2);
          check("a_source", {24'h0, tl_h2d.a_source}, 32'h0);
          check("a_param", {29'h0, tl_h2d.a_param}, 32'h0);
          check("a_user", {14'h0, tl_h2d.a_user}, 32'h0002_4000);
        end
        outst++;
        prev_pend = 1'b0;
      end else if (tl_h2d.a_valid) begin
        prev      = tl_h2d;
        prev_pend = 1'b1;
      end else begin
        prev_pend = 1'b0;
      end
      if (tl_d2h.d_valid && tl_h2d.d_ready) outst--;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst_ni = 1'b0;
    start  = 1'b0;
    base   = 32'h0;
    num    = 16'h0;
    seed   = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_ni = 1'b1;
    zero_run("zero_after_reset");

    // Ideal memory, zero-wait.
    arm(32'h1000, 4, 32'hA5A5_A5A5);
    launch();
    finish_run("basic");

    // Bit 0 of the word at 0x1008 corrupted on store.
    corrupt_en  = 1'b1;
    corrupt_adr = 32'h1008;
    arm(32'h1000, 4, 32'hA5A5_A5A5);
    launch();
    finish_run("corrupt");
    corrupt_en = 1'b0;

    zero_run("zero_after_fail");

    // Slow a_ready, random D latency, stray responses outside RSP states.
    a_delay   = 5;
    d_lat_max = 7;
    spurious  = 1'b1;
    arm(32'h2003, 6, 32'h0F0F_1234);
    launch();
    finish_run("slow");

    // Address wrap past the top of the space.
    a_delay   = 1;
    d_lat_max = 2;
    arm(32'hFFFF_FFF8, 4, 32'hCAFE_F00D);
    launch();
    finish_run("wrap");

    for (int r = 0; r < 4; r++) begin
      a_delay   = int'($urandom_range(3, 0));
      d_lat_max = int'($urandom_range(4, 0));
      spurious  = 1'($urandom);
      derr      = 1'($urandom);
      arm($urandom, int'($urandom_range(8, 1)), $urandom);
      launch();
      finish_run("random");
    end

    // Reset in RD_RSP with erroring responses and start held high.
    derr      = 1'b1;
    spurious  = 1'b1;
    a_delay   = 1;
    d_lat_max = 3;
    arm(32'h3000, 4, 32'h1357_9BDF);
    @(negedge clk);
    start = 1'b1;
    cyc   = 0;
    while (!(tl_h2d.d_ready && exp_q.size() < 4) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_rd_rsp", {31'h0, tl_h2d.d_ready}, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    derr = 1'b0;
    arm(32'h3100, 5, 32'h2468_ACE0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("restart_busy", {31'h0, busy}, 32'h1);
    finish_run("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
